// File: rtl/ahb_sram_if.sv
// AHB-Lite bus bundle between a master/fabric and the SRAM responder.
// hready_broadcast is driven by the fabric, so it sits on the master side.
interface ahb_sram_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready_broadcast;
    logic                  hready;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready_broadcast,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready_broadcast,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with wait states, byte-lane writes and two-cycle ERROR.
// Optional macro AHB_SRAM_ALIGN_CHECK_EN turns misaligned half/word accesses into ERROR.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    ahb_sram_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                state_reg;
    logic [2:0]            cnt_reg;
    logic                  hready_reg;
    logic                  hresp_reg;
    logic                  dp_valid_reg;
    logic                  dp_write_reg;
    logic [IDX_W-1:0]      dp_idx_reg;
    logic [3:0]            dp_strb_reg;
    logic                  rd_ok_reg;
    logic [3:0]            fwd_strb_reg;
    logic [DATA_WIDTH-1:0] fwd_data_reg;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_q;
    logic [DATA_WIDTH-1:0] rd_merged;

    logic                  acc;
    logic                  acc_ok;
    logic                  acc_bad;
    logic [IDX_W-1:0]      acc_idx;
    logic [3:0]            acc_strb;
    logic                  out_range;
    logic                  bad_size;
    logic                  misalign;
    logic                  wr_fire;
    logic                  rd_en;
    logic                  fwd_hit;
    logic                  unused_inputs;

    // hready_reg is high only in IDLE/ERR2, the states that may take a new address phase.
    assign acc       = bus.hsel & bus.htrans[1] & bus.hready_broadcast & hready_reg;
    assign acc_idx   = bus.haddr[IDX_W+1:2];
    assign out_range = |bus.haddr[ADDR_WIDTH-1:IDX_W+2];
    assign bad_size  = bus.hsize[2] | (bus.hsize[1] & bus.hsize[0]);

`ifdef AHB_SRAM_ALIGN_CHECK_EN
    assign misalign = ((bus.hsize == 3'd1) & bus.haddr[0]) |
                      ((bus.hsize == 3'd2) & (|bus.haddr[1:0]));
`else
    assign misalign = 1'b0;
`endif

    assign acc_ok  = acc & ~(out_range | bad_size | misalign);
    assign acc_bad = acc &  (out_range | bad_size | misalign);

    // Without alignment checking, stray low address bits simply align the lanes down.
    always_comb begin
        acc_strb = 4'b0000;
        case (bus.hsize)
            3'd0:    acc_strb = 4'b0001 << bus.haddr[1:0];
            3'd1:    acc_strb = bus.haddr[1] ? 4'b1100 : 4'b0011;
            3'd2:    acc_strb = 4'b1111;
            default: acc_strb = 4'b0000;
        endcase
    end

    assign wr_fire = dp_valid_reg & dp_write_reg & hready_reg;
    assign rd_en   = acc_ok & ~bus.hwrite;
    // A read accepted on the edge that commits a write to the same word misses that write in mem_q.
    assign fwd_hit = rd_en & wr_fire & (dp_idx_reg == acc_idx);

    assign unused_inputs = ^{bus.hburst, bus.hprot, bus.htrans[0]};

    always_ff @(posedge hclk) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (dp_strb_reg[b]) begin
                    mem[dp_idx_reg][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            mem_q <= mem[acc_idx];
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 3'd0;
            hready_reg   <= 1'b1;
            hresp_reg    <= 1'b0;
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_idx_reg   <= '0;
            dp_strb_reg  <= 4'b0000;
            rd_ok_reg    <= 1'b0;
            fwd_strb_reg <= 4'b0000;
            fwd_data_reg <= '0;
        end else begin
            if (hready_reg) begin
                dp_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE, ST_ERR2: begin
                    state_reg  <= ST_IDLE;
                    hready_reg <= 1'b1;
                    hresp_reg  <= 1'b0;
                    if (acc_bad) begin
                        state_reg  <= ST_ERR1;
                        hready_reg <= 1'b0;
                        hresp_reg  <= 1'b1;
                        rd_ok_reg  <= 1'b0;
                    end else if (acc_ok) begin
                        dp_valid_reg <= 1'b1;
                        dp_write_reg <= bus.hwrite;
                        dp_idx_reg   <= acc_idx;
                        dp_strb_reg  <= acc_strb;
                        if (!bus.hwrite) begin
                            rd_ok_reg    <= 1'b1;
                            fwd_strb_reg <= fwd_hit ? dp_strb_reg : 4'b0000;
                            fwd_data_reg <= bus.hwdata;
                        end
                        if (WAIT_STATES > 0) begin
                            state_reg  <= ST_WAIT;
                            cnt_reg    <= 3'(WAIT_STATES);
                            hready_reg <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        state_reg  <= ST_IDLE;
                        hready_reg <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_reg  <= ST_ERR2;
                    hready_reg <= 1'b1;
                    hresp_reg  <= 1'b1;
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    hready_reg <= 1'b1;
                    hresp_reg  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign rd_merged[8*gi +: 8] = fwd_strb_reg[gi] ? fwd_data_reg[8*gi +: 8] : mem_q[8*gi +: 8];
    end

    assign bus.hready = hready_reg;
    assign bus.hresp  = hresp_reg;
    assign bus.hrdata = rd_ok_reg ? rd_merged : '0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait and one 3-wait-state instance.
module tb_ahb_sram_slave;
    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic rst0_n = 1'b0;
    logic rst3_n = 1'b0;
    logic block0 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ahb_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    ahb_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    // Single slave on each bus, so the fabric HREADY is the slave's own HREADYOUT.
    assign bus0.hready_broadcast = bus0.hready & ~block0;
    assign bus3.hready_broadcast = bus3.hready;

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(rst0_n), .bus(bus0));
    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .hclk(hclk), .hresetn(rst3_n), .bus(bus3));

    task automatic tick();
        @(negedge hclk);
    endtask

    task automatic a0(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr);
        bus0.hsel = sel; bus0.htrans = trans; bus0.hwrite = wr; bus0.hsize = size;
        bus0.haddr = addr; bus0.hburst = 3'd0; bus0.hprot = 4'd0;
        if (sel && trans[1]) $display("dut0 %s size=%0d addr=0x%08h", wr ? "WR" : "RD", size, addr);
    endtask

    task automatic a3(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr);
        bus3.hsel = sel; bus3.htrans = trans; bus3.hwrite = wr; bus3.hsize = size;
        bus3.haddr = addr; bus3.hburst = 3'd0; bus3.hprot = 4'd0;
        if (sel && trans[1]) $display("dut3 %s size=%0d addr=0x%08h", wr ? "WR" : "RD", size, addr);
    endtask

    task automatic test_reset();
        a0(0, 0, 0, 0, 0); a3(0, 0, 0, 0, 0);
        bus0.hwdata = 0; bus3.hwdata = 0;
        rst0_n = 1'b0; rst3_n = 1'b0;
        repeat (3) tick();
        checks++; if (bus0.hready !== 1'b1) begin errors++; $display("FAIL rst0_hready got %b exp 1", bus0.hready); end
        checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("FAIL rst0_hresp got %b exp 0", bus0.hresp); end
        checks++; if (bus0.hrdata !== 32'h0) begin errors++; $display("FAIL rst0_hrdata got %h exp 0", bus0.hrdata); end
        checks++; if (bus3.hready !== 1'b1) begin errors++; $display("FAIL rst3_hready got %b exp 1", bus3.hready); end
        checks++; if (bus3.hresp !== 1'b0) begin errors++; $display("FAIL rst3_hresp got %b exp 0", bus3.hresp); end
        checks++; if (bus3.hrdata !== 32'h0) begin errors++; $display("FAIL rst3_hrdata got %h exp 0", bus3.hrdata); end
        rst0_n = 1'b1; rst3_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_wait();
        a0(1, 2, 1, 2, 32'h10); tick();
        checks++; if (bus0.hready !== 1'b1) begin errors++; $display("FAIL zw_wr_ready got %b exp 1", bus0.hready); end
        bus0.hwdata = 32'hDEADBEEF; a0(1, 2, 0, 2, 32'h10); tick();
        checks++; if (bus0.hready !== 1'b1 || bus0.hresp !== 1'b0) begin errors++; $display("FAIL zw_rd_resp got ready=%b resp=%b exp 1/0", bus0.hready, bus0.hresp); end
        checks++; if (bus0.hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_fwd got %h exp deadbeef", bus0.hrdata); end
        a0(0, 0, 0, 0, 0); tick();
        a0(1, 2, 0, 2, 32'h10); tick();
        checks++; if (bus0.hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_mem got %h exp deadbeef", bus0.hrdata); end
        a0(0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_byte_write();
        a0(1, 2, 1, 2, 32'h20); tick();
        bus0.hwdata = 32'h11223344; a0(0, 0, 0, 0, 0); tick();
        a0(1, 2, 1, 0, 32'h23); tick();
        bus0.hwdata = 32'hAA000000; a0(1, 2, 0, 2, 32'h20); tick();
        checks++; if (bus0.hrdata !== 32'hAA223344) begin errors++; $display("FAIL bw_fwd got %h exp aa223344", bus0.hrdata); end
        a0(0, 0, 0, 0, 0); tick();
        a0(1, 2, 0, 2, 32'h20); tick();
        checks++; if (bus0.hrdata !== 32'hAA223344) begin errors++; $display("FAIL bw_mem got %h exp aa223344", bus0.hrdata); end
        a0(1, 2, 1, 1, 32'h22); tick();
        bus0.hwdata = 32'hBEEF0000; a0(0, 0, 0, 0, 0); tick();
        a0(1, 2, 0, 2, 32'h20); tick();
        checks++; if (bus0.hrdata !== 32'hBEEF3344) begin errors++; $display("FAIL hw_mem got %h exp beef3344", bus0.hrdata); end
        a0(0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_misalign();
        logic [31:0] exp_w0;
        a0(1, 2, 1, 2, 32'h00); tick();
        bus0.hwdata = 32'h01020304; a0(0, 0, 0, 0, 0); tick();
        a0(1, 2, 1, 2, 32'h02); tick();
        bus0.hwdata = 32'h55667788; a0(0, 0, 0, 0, 0);
`ifdef AHB_SRAM_ALIGN_CHECK_EN
        checks++; if (bus0.hready !== 1'b0 || bus0.hresp !== 1'b1) begin errors++; $display("FAIL mis_err1 got ready=%b resp=%b exp 0/1", bus0.hready, bus0.hresp); end
        tick();
        exp_w0 = 32'h01020304;
`else
        checks++; if (bus0.hready !== 1'b1 || bus0.hresp !== 1'b0) begin errors++; $display("FAIL mis_okay got ready=%b resp=%b exp 1/0", bus0.hready, bus0.hresp); end
        exp_w0 = 32'h55667788;
`endif
        tick(); tick();
        a0(1, 2, 0, 2, 32'h00); tick();
        checks++; if (bus0.hrdata !== exp_w0) begin errors++; $display("FAIL mis_word0 got %h exp %h", bus0.hrdata, exp_w0); end
        a0(0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_error();
        a0(1, 2, 0, 2, 32'h1000); tick();
        checks++; if (bus0.hready !== 1'b0 || bus0.hresp !== 1'b1) begin errors++; $display("FAIL err1 got ready=%b resp=%b exp 0/1", bus0.hready, bus0.hresp); end
        checks++; if (bus0.hrdata !== 32'h0) begin errors++; $display("FAIL err1_rdata got %h exp 0", bus0.hrdata); end
        a0(0, 0, 0, 0, 0); tick();
        checks++; if (bus0.hready !== 1'b1 || bus0.hresp !== 1'b1) begin errors++; $display("FAIL err2 got ready=%b resp=%b exp 1/1", bus0.hready, bus0.hresp); end
        tick();
        checks++; if (bus0.hready !== 1'b1 || bus0.hresp !== 1'b0) begin errors++; $display("FAIL err_done got ready=%b resp=%b exp 1/0", bus0.hready, bus0.hresp); end
        a0(1, 2, 1, 2, 32'h1010); tick();
        bus0.hwdata = 32'hBAD0BAD0; a0(0, 0, 0, 0, 0); tick(); tick();
        a0(1, 2, 0, 3, 32'h10); tick();
        checks++; if (bus0.hready !== 1'b0 || bus0.hresp !== 1'b1) begin errors++; $display("FAIL size_err got ready=%b resp=%b exp 0/1", bus0.hready, bus0.hresp); end
        a0(0, 0, 0, 0, 0); tick(); tick();
        a0(1, 2, 0, 2, 32'h10); tick();
        checks++; if (bus0.hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL err_nowrite got %h exp deadbeef", bus0.hrdata); end
        a0(0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_no_accept();
        block0 = 1'b1; a0(1, 2, 1, 2, 32'h10); tick();
        block0 = 1'b0; bus0.hwdata = 32'h12345678; a0(0, 2, 1, 2, 32'h10); tick();
        a0(1, 1, 1, 2, 32'h10); tick();
        checks++; if (bus0.hready !== 1'b1 || bus0.hresp !== 1'b0) begin errors++; $display("FAIL busy_okay got ready=%b resp=%b exp 1/0", bus0.hready, bus0.hresp); end
        a0(0, 0, 0, 0, 0); tick();
        a0(1, 2, 0, 2, 32'h10); tick();
        checks++; if (bus0.hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL no_accept got %h exp deadbeef", bus0.hrdata); end
        a0(0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_back_to_back();
        a0(1, 2, 1, 2, 32'h30); tick();
        checks++; if (bus0.hready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b exp 1", bus0.hready); end
        bus0.hwdata = 32'hA1A1A1A1; a0(1, 3, 1, 2, 32'h34); tick();
        checks++; if (bus0.hready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b exp 1", bus0.hready); end
        bus0.hwdata = 32'hB2B2B2B2; a0(1, 2, 0, 2, 32'h30); tick();
        checks++; if (bus0.hready !== 1'b1 || bus0.hrdata !== 32'hA1A1A1A1) begin errors++; $display("FAIL b2b_rd30 got ready=%b data=%h exp 1/a1a1a1a1", bus0.hready, bus0.hrdata); end
        a0(1, 3, 0, 2, 32'h34); tick();
        checks++; if (bus0.hready !== 1'b1 || bus0.hrdata !== 32'hB2B2B2B2) begin errors++; $display("FAIL b2b_rd34 got ready=%b data=%h exp 1/b2b2b2b2", bus0.hready, bus0.hrdata); end
        a0(0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_wait_states();
        int n;
        a3(1, 2, 1, 2, 32'h40); tick();
        bus3.hwdata = 32'h0BADF00D; a3(0, 0, 0, 0, 0);
        n = 0;
        while (bus3.hready !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (n !== 3) begin errors++; $display("FAIL ws_wr_len got %0d exp 3", n); end
        tick();
        a3(1, 2, 0, 2, 32'h40); tick();
        a3(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus3.hready !== 1'b0) begin errors++; $display("FAIL ws_rd_wait%0d got %b exp 0", i, bus3.hready); end
            tick();
        end
        checks++; if (bus3.hready !== 1'b1 || bus3.hresp !== 1'b0) begin errors++; $display("FAIL ws_rd_done got ready=%b resp=%b exp 1/0", bus3.hready, bus3.hresp); end
        checks++; if (bus3.hrdata !== 32'h0BADF00D) begin errors++; $display("FAIL ws_rd_data got %h exp 0badf00d", bus3.hrdata); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int n;
        a3(1, 2, 1, 2, 32'h44); tick();
        bus3.hwdata = 32'h11111111; a3(0, 0, 0, 0, 0);
        n = 0; while (bus3.hready !== 1'b1 && n < 10) begin tick(); n++; end
        tick();
        a3(1, 2, 0, 2, 32'h44); tick();
        a3(0, 0, 0, 0, 0);
        n = 0; while (bus3.hready !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (n !== 3 || bus3.hrdata !== 32'h11111111) begin errors++; $display("FAIL rmw_pre_read got n=%0d data=%h exp 3/11111111", n, bus3.hrdata); end
        tick();
        a3(1, 2, 1, 2, 32'h44); tick();
        bus3.hwdata = 32'hCAFEF00D; a3(0, 0, 0, 0, 0);
        checks++; if (bus3.hready !== 1'b0) begin errors++; $display("FAIL rmw_in_wait got %b exp 0", bus3.hready); end
        rst3_n = 1'b0; #1;
        checks++; if (bus3.hready !== 1'b1 || bus3.hresp !== 1'b0) begin errors++; $display("FAIL rmw_rst_resp got ready=%b resp=%b exp 1/0", bus3.hready, bus3.hresp); end
        checks++; if (bus3.hrdata !== 32'h0) begin errors++; $display("FAIL rmw_rst_rdata got %h exp 0", bus3.hrdata); end
        tick();
        rst3_n = 1'b1; tick();
        a3(1, 2, 0, 2, 32'h44); tick();
        a3(0, 0, 0, 0, 0);
        n = 0; while (bus3.hready !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (n !== 3 || bus3.hrdata !== 32'h11111111) begin errors++; $display("FAIL rmw_nowrite got n=%0d data=%h exp 3/11111111", n, bus3.hrdata); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_byte_write();
        test_misalign();
        test_error();
        test_no_accept();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
